// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC generator with a 2-entry {pc, inst} fetch FIFO towards decode.
// Optional FETCH_ALIGN_CHECK_EN: force word alignment of redirects and flag misaligned targets.
module pc_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        ce_o,
    output logic [31:0] pc_o,
    input  logic [31:0] inst_i,
    output logic        if_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        adr_err_o
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
    logic [31:0] e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;
    logic        adr_err_q, adr_err_d;

    logic        pop;
    logic        issue;
    logic [31:0] redirect_pc;
    logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_pc = {branch_target_i[31:2], 2'b00};
    assign misaligned  = |branch_target_i[1:0];
`else
    assign redirect_pc = branch_target_i;
    assign misaligned  = 1'b0;
`endif

    assign pop   = (count_q != 2'd0) && id_ready_i;
    // A full FIFO may still issue when decode frees the head in the same cycle.
    assign issue = (state_q == ST_RUN) && !stall_i && !branch_flag_i &&
                   ((count_q != 2'd2) || pop);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        e0_pc_d   = e0_pc_q;
        e0_inst_d = e0_inst_q;
        e1_pc_d   = e1_pc_q;
        e1_inst_d = e1_inst_q;
        adr_err_d = branch_flag_i && misaligned;

        if (branch_flag_i) begin
            state_d = ST_RUN;
            pc_d    = redirect_pc;
            count_d = 2'd0;
        end else if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            case ({issue, pop})
                2'b01: begin
                    e0_pc_d   = e1_pc_q;
                    e0_inst_d = e1_inst_q;
                    count_d   = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_pc_d   = pc_q;
                        e0_inst_d = inst_i;
                    end else begin
                        e1_pc_d   = pc_q;
                        e1_inst_d = inst_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // Head leaves, new entry lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        e0_pc_d   = pc_q;
                        e0_inst_d = inst_i;
                    end else begin
                        e0_pc_d   = e1_pc_q;
                        e0_inst_d = e1_inst_q;
                        e1_pc_d   = pc_q;
                        e1_inst_d = inst_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= 32'd0;
            count_q   <= 2'd0;
            e0_pc_q   <= 32'd0;
            e0_inst_q <= 32'd0;
            e1_pc_q   <= 32'd0;
            e1_inst_q <= 32'd0;
            adr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            e0_pc_q   <= e0_pc_d;
            e0_inst_q <= e0_inst_d;
            e1_pc_q   <= e1_pc_d;
            e1_inst_q <= e1_inst_d;
            adr_err_q <= adr_err_d;
        end
    end

    assign ce_o       = issue;
    assign pc_o       = pc_q;
    assign if_valid_o = (count_q != 2'd0);
    assign if_pc_o    = if_valid_o ? e0_pc_q : 32'd0;
    assign if_inst_o  = if_valid_o ? e0_inst_q : 32'd0;
    assign adr_err_o  = adr_err_q;

endmodule
